// File: rtl/uart_rx_stream_if.sv
// Byte-stream handshake and status bundle for the uart_rx_stream receiver.
// master: receiver side; slave: line driver / byte consumer side.
`timescale 1ns/1ps
interface uart_rx_stream_if;
  logic       uartRx;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       dataReady;
  logic       frameError;
  logic       overrun;

  modport master (
    input  uartRx,
    input  dataReady,
    output dataOut,
    output dataValid,
    output frameError,
    output overrun
  );

  modport slave (
    output uartRx,
    output dataReady,
    input  dataOut,
    input  dataValid,
    input  frameError,
    input  overrun
  );
endinterface

// File: rtl/uart_rx_stream.sv
// 8N1 oversampling UART receiver with valid/ready byte output and error pulses.
// Define UART_RX_FIFO_EN to replace the 1-entry holding register with a FifoDepth FWFT FIFO.
`timescale 1ns/1ps
module uart_rx_stream #(
  parameter int unsigned ClkFrequency = 100_000_000,
  parameter int unsigned BaudRate     = 115200,
  parameter int unsigned Oversample   = 16,
  parameter int unsigned FifoDepth    = 16
) (
  input  logic              clk100M,
  input  logic              rst,
  uart_rx_stream_if.master  bus
);

  localparam int unsigned Div  = ClkFrequency / (BaudRate * Oversample);
  localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned ScW  = $clog2(Oversample);
  localparam int unsigned Mid  = Oversample / 2 - 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e            r_state, w_state_d;
  logic              r_rx_meta, r_rx_s;
  logic [DivW-1:0]   r_tick_cnt;
  logic [ScW-1:0]    r_sc;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_frame_err;
  logic              r_overrun;

  logic w_tick, w_sample;
  logic w_tick_clr, w_sc_clr, w_bit_clr, w_shift_en, w_byte_done, w_frame_err;

  always_ff @(posedge clk100M) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.uartRx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick   = (r_tick_cnt == DivW'(Div - 1));
  assign w_sample = w_tick && (r_sc == ScW'(Mid));

  always_ff @(posedge clk100M) begin
    if (rst || w_tick_clr) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // sc free-runs modulo Oversample from the start edge, so consecutive MID samples are one bit apart.
  always_ff @(posedge clk100M) begin
    if (rst || w_sc_clr) begin
      r_sc <= '0;
    end else if (w_tick) begin
      r_sc <= (r_sc == ScW'(Oversample - 1)) ? '0 : r_sc + 1'b1;
    end
  end

  always_ff @(posedge clk100M) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (!r_rx_s) w_state_d = StStart;
      StStart: if (w_sample) w_state_d = r_rx_s ? StIdle : StData;
      StData:  if (w_sample && (r_bit_idx == 3'd7)) w_state_d = StStop;
      StStop:  if (w_sample) w_state_d = r_rx_s ? StIdle : StBreak;
      StBreak: if (r_rx_s) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_tick_clr  = (r_state == StIdle) && !r_rx_s;
    w_sc_clr    = (r_state == StIdle);
    w_bit_clr   = (r_state == StStart);
    w_shift_en  = (r_state == StData) && w_sample;
    w_byte_done = (r_state == StStop) && w_sample && r_rx_s;
    w_frame_err = (r_state == StStop) && w_sample && !r_rx_s;
  end

  always_ff @(posedge clk100M) begin
    if (rst) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else if (w_bit_clr) begin
      r_bit_idx <= '0;
    end else if (w_shift_en) begin
      r_shift   <= {r_rx_s, r_shift[7:1]};
      r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk100M) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
    end
  end

  assign bus.frameError = r_frame_err;
  assign bus.overrun    = r_overrun;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned PtrW = $clog2(FifoDepth);

  logic [7:0]    r_mem [FifoDepth];
  logic [PtrW:0] r_wr_ptr, r_rd_ptr;
  logic          w_empty, w_full, w_pop, w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) &&
                   (r_wr_ptr[PtrW-1:0] == r_rd_ptr[PtrW-1:0]);
  assign w_pop   = !w_empty && bus.dataReady;
  // When full, a same-cycle pop frees the slot being written.
  assign w_push  = w_byte_done && (!w_full || w_pop);

  always_ff @(posedge clk100M) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PtrW-1:0]] <= r_shift;
    end
  end

  always_ff @(posedge clk100M) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_overrun <= w_byte_done && w_full && !w_pop;
    end
  end

  assign bus.dataValid = !w_empty;
  assign bus.dataOut   = w_empty ? 8'h00 : r_mem[r_rd_ptr[PtrW-1:0]];
`else
  logic [7:0] r_data;
  logic       r_valid;
  logic       w_xfer;

  assign w_xfer = r_valid && bus.dataReady;

  always_ff @(posedge clk100M) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_byte_done) begin
        if (!r_valid || w_xfer) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.dataValid = r_valid;
  assign bus.dataOut   = r_data;
`endif

endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench for uart_rx_stream: drives 8N1 frames, scoreboards delivered bytes.
`timescale 1ns/1ps
module tb_uart_rx_stream;
  localparam int unsigned BitClks = 864;

  logic clk100M = 1'b0;
  logic rst     = 1'b1;

  uart_rx_stream_if bus ();

  uart_rx_stream u_dut (
    .clk100M (clk100M),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk100M = ~clk100M;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_fe    = 0;
  int         n_ov    = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk100M) begin
    if (!rst) begin
      if (bus.frameError) n_fe++;
      if (bus.overrun)    n_ov++;
      if (bus.frameError && bus.overrun) check_eq("flags_exclusive", 1, 0);
      if (bus.dataValid && bus.dataReady) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_byte", {24'h0, bus.dataOut}, 32'hFFFF_FFFF);
        end else begin
          check_eq("rx_byte", {24'h0, bus.dataOut}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic wait_bits(input int unsigned clks);
    repeat (clks) @(posedge clk100M);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned extra_low);
    bus.uartRx = 1'b0;
    wait_bits(BitClks);
    for (int i = 0; i < 8; i++) begin
      bus.uartRx = d[i];
      wait_bits(BitClks);
    end
    bus.uartRx = stop;
    wait_bits(BitClks);
    if (extra_low != 0) begin
      bus.uartRx = 1'b0;
      wait_bits(extra_low);
    end
    bus.uartRx = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 * BitClks && exp_q.size() != 0; i++) @(posedge clk100M);
    #1;
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_dataOut"},    {24'h0, bus.dataOut}, 0);
    check_eq({tag, "_dataValid"},  {31'h0, bus.dataValid}, 0);
    check_eq({tag, "_frameError"}, {31'h0, bus.frameError}, 0);
    check_eq({tag, "_overrun"},    {31'h0, bus.overrun}, 0);
  endtask

  initial begin
    int         fe0, ov0;
    logic [7:0] partial;
    bus.uartRx    = 1'b1;
    bus.dataReady = 1'b1;
    repeat (4) @(posedge clk100M);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    wait_bits(BitClks);

    // Clean frame, consumer always ready.
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1, 0);
    wait_bits(BitClks);
    wait_drain("drain_0x41");
    check_eq("fe_after_0x41", n_fe, 0);
    check_eq("ov_after_0x41", n_ov, 0);

    // Short low glitch shorter than half a bit.
    bus.uartRx = 1'b0;
    wait_bits(162);
    bus.uartRx = 1'b1;
    wait_bits(2 * BitClks);
    check_eq("glitch_valid", {31'h0, bus.dataValid}, 0);
    check_eq("glitch_fe", n_fe, 0);

    // Framing error followed by a held-low line, then a clean frame.
    fe0 = n_fe;
    send_frame(8'h55, 1'b0, 2 * BitClks);
    wait_bits(BitClks);
    check_eq("break_fe_count", n_fe - fe0, 1);
    check_eq("break_valid", {31'h0, bus.dataValid}, 0);
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1, 0);
    wait_bits(BitClks);
    wait_drain("drain_0xA3");
    check_eq("fe_after_0xA3", n_fe - fe0, 1);

    ov0 = n_ov;
    @(posedge clk100M);
    #1;
    bus.dataReady = 1'b0;
`ifdef UART_RX_FIFO_EN
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 0);
    end
    wait_bits(BitClks);
    check_eq("fifo_overrun_count", n_ov - ov0, 1);
    check_eq("fifo_head_valid", {31'h0, bus.dataValid}, 1);
    check_eq("fifo_head_data", {24'h0, bus.dataOut}, 0);
    bus.dataReady = 1'b1;
    wait_drain("drain_fifo");
`else
    exp_q.push_back(8'h10);
    send_frame(8'h10, 1'b1, 0);
    wait_bits(BitClks);
    check_eq("hold_first_ov", n_ov - ov0, 0);
    send_frame(8'h20, 1'b1, 0);
    wait_bits(BitClks);
    check_eq("hold_overrun_count", n_ov - ov0, 1);
    check_eq("hold_valid", {31'h0, bus.dataValid}, 1);
    check_eq("hold_data", {24'h0, bus.dataOut}, 32'h10);
    bus.dataReady = 1'b1;
    wait_drain("drain_hold");
`endif
    wait_bits(2);
    check_eq("valid_after_drain", {31'h0, bus.dataValid}, 0);

    // Reset in the middle of data bit 4, then a clean frame.
    fe0 = n_fe;
    ov0 = n_ov;
    partial = 8'hC3;
    bus.uartRx = 1'b0;
    wait_bits(BitClks);
    for (int i = 0; i < 5; i++) begin
      bus.uartRx = partial[i];
      wait_bits((i == 4) ? BitClks / 2 : BitClks);
    end
    rst = 1'b1;
    wait_bits(1);
    rst = 1'b0;
    bus.uartRx = 1'b1;
    check_idle_outputs("midreset");
    wait_bits(3 * BitClks);
    check_idle_outputs("aborted");
    check_eq("aborted_fe", n_fe - fe0, 0);
    check_eq("aborted_ov", n_ov - ov0, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 0);
    wait_bits(BitClks);
    wait_drain("drain_0x7E");
    check_eq("final_fe", n_fe - fe0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
